// File: rtl/uart_rx_sampler.sv
// 8N1 UART receive front end: two-flop synchroniser, start-bit glitch rejection,
// 3-sample majority vote at each bit centre, byte/frame-error/overrun pulses.
module uart_rx_sampler #(
    parameter logic [19:0] P_BIT_CLOCKS = 20'd108
) (
    input  logic       iCLOCK,
    input  logic       inRESET,
    input  logic       iRESET_SYNC,
    input  logic       iUART_RXD,
    input  logic       iRX_FULL,
    output logic       oRX_VALID,
    output logic [7:0] oRX_DATA,
    output logic       oRX_FRAME_ERR,
    output logic       oRX_OVERRUN,
    output logic       oRX_BUSY
);

    localparam logic [19:0] P_HALF = P_BIT_CLOCKS / 20'd2;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    logic        rxdMeta;
    logic        rxdS;
    logic [2:0]  state;
    logic [19:0] bitCnt;
    logic [2:0]  bitIdx;
    logic [7:0]  shiftReg;
    logic        samp0;
    logic        samp1;
    logic        majority;
    logic        isDecide;
    logic        isWrap;

    // Third vote is the live synchronised sample in the decision cycle.
    always_comb begin
        majority = (samp0 & samp1) | (samp0 & rxdS) | (samp1 & rxdS);
        isDecide = (bitCnt == P_HALF + 20'd1);
        isWrap   = (bitCnt == P_BIT_CLOCKS - 20'd1);
    end

    assign oRX_BUSY = (state != ST_IDLE);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rxdMeta       <= 1'b1;
            rxdS          <= 1'b1;
            state         <= ST_IDLE;
            bitCnt        <= '0;
            bitIdx        <= '0;
            shiftReg      <= '0;
            samp0         <= 1'b1;
            samp1         <= 1'b1;
            oRX_VALID     <= 1'b0;
            oRX_DATA      <= '0;
            oRX_FRAME_ERR <= 1'b0;
            oRX_OVERRUN   <= 1'b0;
        end else if (iRESET_SYNC) begin
            rxdMeta       <= 1'b1;
            rxdS          <= 1'b1;
            state         <= ST_IDLE;
            bitCnt        <= '0;
            bitIdx        <= '0;
            shiftReg      <= '0;
            samp0         <= 1'b1;
            samp1         <= 1'b1;
            oRX_VALID     <= 1'b0;
            oRX_DATA      <= '0;
            oRX_FRAME_ERR <= 1'b0;
            oRX_OVERRUN   <= 1'b0;
        end else begin
            rxdMeta       <= iUART_RXD;
            rxdS          <= rxdMeta;
            oRX_VALID     <= 1'b0;
            oRX_FRAME_ERR <= 1'b0;
            oRX_OVERRUN   <= 1'b0;

            if (bitCnt == P_HALF - 20'd1) samp0 <= rxdS;
            if (bitCnt == P_HALF)         samp1 <= rxdS;

            case (state)
                ST_IDLE: begin
                    bitCnt <= '0;
                    if (!rxdS) state <= ST_START;
                end
                ST_START: begin
                    if (isDecide && majority) begin
                        state  <= ST_IDLE;
                        bitCnt <= '0;
                    end else if (isWrap) begin
                        state  <= ST_DATA;
                        bitCnt <= '0;
                        bitIdx <= '0;
                    end else begin
                        bitCnt <= bitCnt + 20'd1;
                    end
                end
                ST_DATA: begin
                    if (isDecide) shiftReg <= {majority, shiftReg[7:1]};
                    if (isWrap) begin
                        bitCnt <= '0;
                        if (bitIdx == 3'd7) begin
                            state  <= ST_STOP;
                            bitIdx <= '0;
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                        end
                    end else begin
                        bitCnt <= bitCnt + 20'd1;
                    end
                end
                ST_STOP: begin
                    // Frame ends at the stop-bit decision so the next start edge is never missed.
                    if (isDecide) begin
                        bitCnt <= '0;
                        if (majority) begin
                            oRX_VALID   <= 1'b1;
                            oRX_DATA    <= shiftReg;
                            oRX_OVERRUN <= iRX_FULL;
                            state       <= ST_IDLE;
                        end else begin
                            oRX_FRAME_ERR <= 1'b1;
                            state         <= ST_WAIT_IDLE;
                        end
                    end else begin
                        bitCnt <= bitCnt + 20'd1;
                    end
                end
                ST_WAIT_IDLE: begin
                    bitCnt <= '0;
                    if (rxdS) state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    bitCnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: frames driven at the pad, pulses logged
// by a monitor and compared against hand-computed values.
module tb_uart_rx_sampler;

    localparam int BIT = 108;

    logic       iCLOCK = 1'b0;
    logic       inRESET;
    logic       iRESET_SYNC;
    logic       iUART_RXD;
    logic       iRX_FULL;
    logic       oRX_VALID;
    logic [7:0] oRX_DATA;
    logic       oRX_FRAME_ERR;
    logic       oRX_OVERRUN;
    logic       oRX_BUSY;

    uart_rx_sampler #(.P_BIT_CLOCKS(20'd108)) dut (
        .iCLOCK       (iCLOCK),
        .inRESET      (inRESET),
        .iRESET_SYNC  (iRESET_SYNC),
        .iUART_RXD    (iUART_RXD),
        .iRX_FULL     (iRX_FULL),
        .oRX_VALID    (oRX_VALID),
        .oRX_DATA     (oRX_DATA),
        .oRX_FRAME_ERR(oRX_FRAME_ERR),
        .oRX_OVERRUN  (oRX_OVERRUN),
        .oRX_BUSY     (oRX_BUSY)
    );

    always #5 iCLOCK = ~iCLOCK;

    int numChecks = 0;
    int numFails  = 0;
    int cyc = 0;
    int validCnt = 0, ferrCnt = 0, bothHigh = 0, backToBack = 0, ovrStray = 0;
    int busyRiseCyc = 0, busyFallCyc = 0, validCyc = 0;
    logic       busyPrev = 1'b0, validPrev = 1'b0, ferrPrev = 1'b0, ovrPrev = 1'b0;
    logic [7:0] lastData = 8'h00, prevData = 8'h00;
    logic       lastOvr = 1'b0;

    task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    always @(posedge iCLOCK) cyc++;

    always @(negedge iCLOCK) begin
        if (oRX_BUSY && !busyPrev) busyRiseCyc = cyc;
        if (!oRX_BUSY && busyPrev) busyFallCyc = cyc;
        if (oRX_VALID) begin
            validCnt++;
            validCyc = cyc;
            prevData = lastData;
            lastData = oRX_DATA;
            lastOvr  = oRX_OVERRUN;
        end
        if (oRX_FRAME_ERR) ferrCnt++;
        if (oRX_VALID && oRX_FRAME_ERR) bothHigh++;
        if (oRX_OVERRUN && !oRX_VALID) ovrStray++;
        if ((oRX_VALID && validPrev) || (oRX_FRAME_ERR && ferrPrev) || (oRX_OVERRUN && ovrPrev))
            backToBack++;
        busyPrev  = oRX_BUSY;
        validPrev = oRX_VALID;
        ferrPrev  = oRX_FRAME_ERR;
        ovrPrev   = oRX_OVERRUN;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iCLOCK);
            #1 iUART_RXD = 1'b1;
        end
    endtask

    // abortPos: frame bit position (0=start, 1..8=data) at which a sync reset is pulsed; -1 for none
    task automatic sendFrame(input logic [7:0] d, input logic stopVal, input logic noise, input int abortPos);
        logic [9:0] bits;
        bits = {stopVal, d, 1'b0};
        for (int pos = 0; pos < 10; pos++) begin
            for (int c = 0; c < BIT; c++) begin
                @(posedge iCLOCK);
                #1;
                if (pos == abortPos && c == 30) begin
                    checkEq("abortBusyBefore", 32'(oRX_BUSY), 32'd1);
                    iRESET_SYNC = 1'b1;
                    iUART_RXD   = 1'b1;
                    @(posedge iCLOCK);
                    #1 iRESET_SYNC = 1'b0;
                    checkEq("abortBusyAfter", 32'(oRX_BUSY), 32'd0);
                    return;
                end
                iUART_RXD = bits[pos] ^ (noise && pos >= 1 && pos <= 8 && c == 55);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0;
        inRESET = 1'b0; iRESET_SYNC = 1'b0; iUART_RXD = 1'b1; iRX_FULL = 1'b0;
        repeat (3) @(posedge iCLOCK);
        #1;
        checkEq("resetOutputs", 32'({oRX_VALID, oRX_FRAME_ERR, oRX_OVERRUN, oRX_BUSY, oRX_DATA}), 32'd0);
        inRESET = 1'b1;

        // 0xA5 with latency measurement
        idle(162);
        v0 = validCnt; f0 = ferrCnt;
        sendFrame(8'hA5, 1'b1, 1'b0, -1);
        idle(162);
        checkEq("a5Pulses", 32'(validCnt - v0), 32'd1);
        checkEq("a5Data", 32'(lastData), 32'hA5);
        checkEq("a5Latency", 32'(validCyc - busyRiseCyc), 32'd1028);
        checkEq("a5FrameErr", 32'(ferrCnt - f0), 32'd0);
        checkEq("a5Overrun", 32'(lastOvr), 32'd0);

        // 20-cycle start glitch
        v0 = validCnt;
        for (int i = 0; i < 20; i++) begin
            @(posedge iCLOCK);
            #1 iUART_RXD = 1'b0;
        end
        idle(200);
        checkEq("glitchBusyLen", 32'(busyFallCyc - busyRiseCyc), 32'd56);
        checkEq("glitchPulses", 32'(validCnt - v0), 32'd0);
        sendFrame(8'h3C, 1'b1, 1'b0, -1);
        idle(162);
        checkEq("glitchNextData", 32'(lastData), 32'h3C);
        checkEq("glitchNextPulses", 32'(validCnt - v0), 32'd1);

        // Stop bit 0 followed by break
        v0 = validCnt; f0 = ferrCnt;
        sendFrame(8'h7E, 1'b0, 1'b0, -1);
        for (int i = 0; i < 3000; i++) begin
            @(posedge iCLOCK);
            #1 iUART_RXD = 1'b0;
        end
        checkEq("breakFrameErr", 32'(ferrCnt - f0), 32'd1);
        checkEq("breakPulses", 32'(validCnt - v0), 32'd0);
        checkEq("breakDataHeld", 32'(lastData), 32'h3C);
        checkEq("breakBusy", 32'(oRX_BUSY), 32'd1);
        idle(300);
        sendFrame(8'h81, 1'b1, 1'b0, -1);
        idle(162);
        checkEq("afterBreakData", 32'(lastData), 32'h81);
        checkEq("afterBreakPulses", 32'(validCnt - v0), 32'd1);
        checkEq("afterBreakFrameErr", 32'(ferrCnt - f0), 32'd1);

        // Noise immunity and back-to-back frames
        sendFrame(8'h55, 1'b1, 1'b1, -1);
        idle(162);
        checkEq("noiseData", 32'(lastData), 32'h55);
        v0 = validCnt;
        sendFrame(8'h00, 1'b1, 1'b0, -1);
        sendFrame(8'hFF, 1'b1, 1'b0, -1);
        idle(162);
        checkEq("b2bPulses", 32'(validCnt - v0), 32'd2);
        checkEq("b2bFirst", 32'(prevData), 32'h00);
        checkEq("b2bSecond", 32'(lastData), 32'hFF);

        // Overrun
        iRX_FULL = 1'b1;
        sendFrame(8'h12, 1'b1, 1'b0, -1);
        idle(162);
        iRX_FULL = 1'b0;
        checkEq("ovrData", 32'(lastData), 32'h12);
        checkEq("ovrFlag", 32'(lastOvr), 32'd1);

        // Sync reset during data bit 4
        v0 = validCnt;
        sendFrame(8'hC3, 1'b1, 1'b0, 5);
        idle(1200);
        checkEq("abortPulses", 32'(validCnt - v0), 32'd0);
        sendFrame(8'h99, 1'b1, 1'b0, -1);
        idle(162);
        checkEq("abortNextData", 32'(lastData), 32'h99);
        checkEq("abortNextPulses", 32'(validCnt - v0), 32'd1);

        // Async reset mid-frame
        for (int i = 0; i < 300; i++) begin
            @(posedge iCLOCK);
            #1 iUART_RXD = 1'b0;
        end
        #2;
        checkEq("asyncBusyBefore", 32'(oRX_BUSY), 32'd1);
        inRESET = 1'b0;
        #1;
        checkEq("asyncOutputs", 32'({oRX_VALID, oRX_FRAME_ERR, oRX_OVERRUN, oRX_BUSY, oRX_DATA}), 32'd0);
        iUART_RXD = 1'b1;
        @(posedge iCLOCK);
        #1 inRESET = 1'b1;
        idle(50);
        checkEq("asyncIdleBusy", 32'(oRX_BUSY), 32'd0);

        checkEq("validWithFrameErr", 32'(bothHigh), 32'd0);
        checkEq("consecutivePulses", 32'(backToBack), 32'd0);
        checkEq("overrunWithoutValid", 32'(ovrStray), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Serial front end of the SCI receive path. Sits between the iUART_RXD pad and the RX sync FIFO write port.
- Synchronises the asynchronous RXD line and detects start bits, rejecting glitches.
- Recovers 8N1 frames (LSB first) using a 3-sample majority vote at each bit centre.
- Presents each received byte as a one-cycle valid pulse with frame-error and overrun status.

Parameters:
- P_BIT_CLOCKS, 20'd108, iCLOCK cycles per bit period. Legal range is 8 to 2^20-1.
- P_HALF, P_BIT_CLOCKS/2 (integer division), bit-centre counter value. Derived; do not override.

Ports:
- iCLOCK  in  1  system clock
- inRESET  in  1  asynchronous active-low reset
- iRESET_SYNC  in  1  synchronous clear, active-high
- iUART_RXD  in  1  asynchronous serial input; idle level is 1
- iRX_FULL  in  1  downstream FIFO full flag, used only for overrun reporting
- oRX_VALID  out  1  one-cycle pulse; oRX_DATA is valid in this cycle
- oRX_DATA  out  8  received byte; held until the next valid pulse
- oRX_FRAME_ERR  out  1  one-cycle pulse when the stop bit is sampled as 0
- oRX_OVERRUN  out  1  one-cycle pulse coincident with oRX_VALID when iRX_FULL=1
- oRX_BUSY  out  1  high while a frame is in progress (state is not IDLE)

Behaviour:
- Reset (inRESET=0, asynchronous):
  - Two-flop synchroniser forced to 1/1.
  - State=IDLE, bit counter=0, bit index=0, shift register=0.
  - All outputs 0.
- iRESET_SYNC=1 at a clock edge has the same effect synchronously and overrides every other event, including mid-frame. Any partial frame is discarded with no pulse.
- Synchroniser: rxd_s is iUART_RXD delayed by 2 flops. All decisions use rxd_s only.
- Bit timing:
  - Counter runs 0 to P_BIT_CLOCKS-1 and wraps to 0 at each bit boundary.
  - Sample window covers counter = P_HALF-1, P_HALF and P_HALF+1.
  - The bit value is the majority of those 3 samples, decided at counter = P_HALF+1.
- State machine (IDLE, START, DATA, STOP, WAIT_IDLE):
  - IDLE: when rxd_s=0, go to START with counter=0. This is cycle 0 of the frame.
  - START: at decision, majority=1 is a false start: return to IDLE, no output. Majority=0 means continue counting; at counter wrap go to DATA with bit index=0.
  - DATA: at each decision, shift the majority into the MSB of the shift register (right shift, LSB first on the wire). At wrap, increment the bit index. After the wrap for bit index 7, go to STOP.
  - STOP, majority=1: on the next edge oRX_VALID=1, oRX_DATA=shift register, oRX_OVERRUN=iRX_FULL (sampled at the decision cycle). State returns to IDLE at the same edge, without waiting for the end of the stop bit.
  - STOP, majority=0: on the next edge oRX_FRAME_ERR=1, no oRX_VALID, oRX_DATA unchanged. Go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxd_s=1, then go to IDLE. This handles break conditions.
- Latency: oRX_VALID is high exactly in the cycle ending at clock edge 9*P_BIT_CLOCKS+P_HALF+2 after the frame's cycle-0 edge. With the default, that is 1028 cycles.
- oRX_VALID, oRX_FRAME_ERR and oRX_OVERRUN are never high in two consecutive cycles, and oRX_VALID and oRX_FRAME_ERR are never high together.
- No backpressure: the consumer must accept a pulse in the cycle it is issued. Overrun is reported only; the downstream FIFO drops the byte.
- Single-cycle glitches on rxd_s inside a sample window are outvoted by the majority.
- Back-to-back frames: a start edge arriving any time after the return to IDLE is detected.

Test Plan:
- Default parameter: send 0xA5 at 108 clk/bit, with 1.5 idle bits before and after. Expect oRX_VALID for exactly 1 cycle, 1028 cycles after the start detect, with oRX_DATA=0xA5 and oRX_FRAME_ERR=0.
- Start glitch: drive RXD low for 20 cycles, then high. Expect the state to return to IDLE at counter 55, oRX_BUSY to drop, and no pulse. A following valid 0x3C frame is received as 0x3C.
- Stop bit forced 0 on 0x7E, then a 3000-cycle break (RXD=0), then idle, then 0x81. Expect one oRX_FRAME_ERR pulse and no oRX_VALID during the break, then 0x81 received correctly.
- Noise immunity: invert RXD for 1 cycle at counter 54 of every data bit while sending 0x55. Expect oRX_DATA=0x55. Also send 0x00 then 0xFF back-to-back with no idle gap; expect 2 valid pulses with the correct data.
- Overrun: hold iRX_FULL=1 and send 0x12. Expect oRX_VALID and oRX_OVERRUN high in the same cycle, with oRX_DATA=0x12.
- Reset mid-frame: assert iRESET_SYNC for 1 cycle during data bit 4, then idle, then send 0x99. Expect no pulse for the aborted frame and 0x99 received. Also assert inRESET asynchronously mid-frame; expect all outputs 0 immediately.
